// File: rtl/mux_seq_mac_pkg.sv
// Shared constants, FSM encoding and saturation limits for the sequencing MAC.
// The activation stage uses the same limits.
package mux_seq_mac_pkg;

  localparam int DWIDTH = 32;
  localparam int IWIDTH = 16;
  localparam int SELW   = 4;
  localparam int NTAPS  = 1 << SELW;

  localparam logic signed [DWIDTH-1:0] SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0] SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mux_seq_mac_sat_add.sv
// Combinational signed add that clamps to the DWIDTH-bit two's complement range.
// The sum is formed one bit wider, so a sign mismatch in the top two bits means overflow.
module sat_add_signed #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] y
);

  logic [DWIDTH:0] sum;

  assign sum = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};

  always_comb begin
    y = sum[DWIDTH-1:0];
    if (sum[DWIDTH] != sum[DWIDTH-1]) begin
      y = sum[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mux_seq_mac.sv
// Walks the selector tree through all taps, multiplies each sample by its weight and
// accumulates onto a bias with per-step saturation; one result per run.
module mux_seq_mac #(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 16,
  parameter int SELW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] bias,
  output logic [SELW-1:0]   sel,
  input  logic [IWIDTH-1:0] mux_data,
  input  logic [IWIDTH-1:0] weight,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] result
);

  import mux_seq_mac_pkg::*;

  localparam logic [SELW-1:0] SEL_LAST = {SELW{1'b1}};

  state_t                     state;
  logic signed [DWIDTH-1:0]   acc;
  logic signed [2*IWIDTH-1:0] prod;
  logic                       pv;
  logic signed [2*IWIDTH-1:0] mul;
  logic signed [DWIDTH-1:0]   prod_ext;
  logic [DWIDTH-1:0]          acc_sum;

  assign mul      = $signed(mux_data) * $signed(weight);
  assign prod_ext = DWIDTH'(prod);

  // One saturating adder serves both the in-run accumulate and the final drain step.
  sat_add_signed #(.DWIDTH(DWIDTH)) u_sat_add (
    .a (acc),
    .b (prod_ext),
    .y (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sel    <= '0;
      acc    <= '0;
      prod   <= '0;
      pv     <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          sel <= '0;
          if (start) begin
            acc   <= bias;
            pv    <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          prod <= mul;
          pv   <= 1'b1;
          if (pv) acc <= acc_sum;
          if (sel == SEL_LAST) begin
            sel   <= '0;
            state <= S_DRAIN;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        S_DRAIN: begin
          acc    <= acc_sum;
          result <= acc_sum;
          done   <= 1'b1;
          busy   <= 1'b0;
          pv     <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_seq_mac.sv
// Self-checking bench for mux_seq_mac: randomized and directed runs compared against a
// per-tap saturating sum model computed with wide integer arithmetic.
module tb_mux_seq_mac;

  import mux_seq_mac_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [DWIDTH-1:0]        bias;
  logic [SELW-1:0]          sel;
  logic [IWIDTH-1:0]        mux_data;
  logic [IWIDTH-1:0]        weight;
  logic                     busy;
  logic                     done;
  logic [DWIDTH-1:0]        result;

  logic signed [IWIDTH-1:0] samples [NTAPS];
  logic signed [IWIDTH-1:0] weights [NTAPS];

  int n_cmp;
  int n_bad;

  mux_seq_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .sel      (sel),
    .mux_data (mux_data),
    .weight   (weight),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector tree and weight source stand-ins: combinational lookups on sel.
  always_comb begin
    mux_data = samples[sel];
    weight   = weights[sel];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: bias plus each sample*weight, clamped after every addition.
  function automatic logic [DWIDTH-1:0] ref_mac(input logic signed [DWIDTH-1:0] b);
    longint acc;
    acc = longint'(b);
    for (int i = 0; i < NTAPS; i++) begin
      acc = acc + longint'(samples[i]) * longint'(weights[i]);
      if (acc > longint'(SAT_MAX)) acc = longint'(SAT_MAX);
      if (acc < longint'(SAT_MIN)) acc = longint'(SAT_MIN);
    end
    return acc[DWIDTH-1:0];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_const(input logic signed [IWIDTH-1:0] s, input logic signed [IWIDTH-1:0] w);
    for (int i = 0; i < NTAPS; i++) begin
      samples[i] = s;
      weights[i] = w;
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NTAPS; i++) begin
      samples[i] = IWIDTH'(i + 1);
      weights[i] = 16'sd2;
    end
  endtask

  task automatic load_random(input bit big);
    for (int i = 0; i < NTAPS; i++) begin
      if (big) begin
        samples[i] = IWIDTH'($urandom_range(0, 65535));
        weights[i] = IWIDTH'($urandom_range(0, 65535));
      end else begin
        samples[i] = IWIDTH'($signed($urandom_range(0, 2000)) - 1000);
        weights[i] = IWIDTH'($signed($urandom_range(0, 2000)) - 1000);
      end
    end
  endtask

  // Issues one start pulse from IDLE, then watches up to 40 cycles for done.
  // Extra start pulses are injected after the samples at cycles pa and pb.
  task automatic drive_run(input int pa, input int pb, output int lat, output int busy_cnt,
                           output int sel_err, output logic [DWIDTH-1:0] res);
    lat      = -1;
    busy_cnt = 0;
    sel_err  = 0;
    res      = 'x;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n < NTAPS && sel !== 4'(n)) sel_err++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
      start = (n == pa || n == pb);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({sel, busy, done} !== 6'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset: sel=%0d busy=%b done=%b result=%0d, required all zero", sel, busy, done, result);
    end
  endtask

  task automatic test_idle();
    int seen_done, bad_out;
    seen_done = 0;
    bad_out   = 0;
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done !== 1'b0) seen_done++;
      if (sel !== '0 || busy !== 1'b0) bad_out++;
    end
    n_cmp++;
    if (seen_done != 0 || bad_out != 0) begin
      n_bad++;
      $display("FAIL idle: done_cycles=%0d bad_sel_busy_cycles=%0d, required 0 and 0", seen_done, bad_out);
    end
  endtask

  task automatic test_ramp();
    int lat, bc, se;
    logic [DWIDTH-1:0] res;
    load_ramp();
    bias = '0;
    drive_run(-1, -1, lat, bc, se, res);
    n_cmp++;
    if (se != 0) begin n_bad++; $display("FAIL ramp_sel: %0d wrong sel samples, required 0", se); end
    n_cmp++;
    if (lat != 17) begin n_bad++; $display("FAIL ramp_latency: %0d, required 17", lat); end
    n_cmp++;
    if (bc != 17) begin n_bad++; $display("FAIL ramp_busy: high %0d cycles, required 17", bc); end
    n_cmp++;
    if (res !== 32'd272) begin n_bad++; $display("FAIL ramp_result: %0d, required 272", $signed(res)); end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL ramp_done_pulse: done=%b after pulse, required 0", done); end
  endtask

  task automatic check_run(input string name, input logic [DWIDTH-1:0] b);
    int lat, bc, se;
    logic [DWIDTH-1:0] res, exp;
    bias = b;
    exp  = ref_mac(b);
    drive_run(-1, -1, lat, bc, se, res);
    n_cmp++;
    if (lat != 17 || res !== exp) begin
      n_bad++;
      $display("FAIL %s: latency=%0d result=%0d, required latency=17 result=%0d",
               name, lat, $signed(res), $signed(exp));
    end
  endtask

  task automatic test_signed();
    load_const(-16'sd100, 16'sd300);
    check_run("signed", 32'sd5);
    n_cmp++;
    if (result !== 32'(-479995)) begin
      n_bad++;
      $display("FAIL signed_const: %0d, required -479995", $signed(result));
    end
  endtask

  task automatic test_saturation();
    load_const(-16'sd32768, -16'sd32768);
    check_run("sat_pos", '0);
    n_cmp++;
    if (result !== 32'h7fff_ffff) begin
      n_bad++; $display("FAIL sat_pos_const: %0d, required 2147483647", $signed(result));
    end
    load_const(-16'sd32768, 16'sd32767);
    check_run("sat_neg", 32'h8000_0000);
    n_cmp++;
    if (result !== 32'h8000_0000) begin
      n_bad++; $display("FAIL sat_neg_const: %0d, required -2147483648", $signed(result));
    end
    // Clamp early then pull back: a clamped value must be the base for later taps.
    load_const(16'sd30000, 16'sd30000);
    for (int i = 8; i < NTAPS; i++) begin
      samples[i] = -16'sd30000;
    end
    check_run("sat_recover", 32'sd1000);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      load_random(r[0]);
      check_run($sformatf("random_%0d", r), DWIDTH'($urandom()));
    end
  endtask

  task automatic test_handshake();
    int lat, bc, se, extra;
    logic [DWIDTH-1:0] res, exp;
    load_random(1'b0);
    bias = DWIDTH'($urandom_range(0, 100000));
    exp  = ref_mac(bias);
    drive_run(3, 8, lat, bc, se, res);
    n_cmp++;
    if (lat != 17 || bc != 17 || res !== exp) begin
      n_bad++;
      $display("FAIL handshake_run: latency=%0d busy=%0d result=%0d, required 17 17 %0d",
               lat, bc, $signed(res), $signed(exp));
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL handshake_extra_done: %0d, required 0", extra); end
    n_cmp++;
    if (result !== exp) begin
      n_bad++; $display("FAIL result_hold: %0d, required %0d", $signed(result), $signed(exp));
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [DWIDTH-1:0] exp1, exp2, res1, res2;
    lat1 = -1;
    lat2 = -1;
    res1 = 'x;
    res2 = 'x;
    load_ramp();
    bias = DWIDTH'(32'sd7);
    exp1 = ref_mac(bias);
    start = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin lat1 = n; res1 = result; break; end
      tick();
    end
    // start still high in the done cycle: a second run is taken on the next edge.
    load_const(-16'sd50, 16'sd41);
    bias = DWIDTH'(-32'sd3);
    exp2 = ref_mac(bias);
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) begin lat2 = n; res2 = result; break; end
      tick();
    end
    n_cmp++;
    if (lat1 != 17 || res1 !== exp1) begin
      n_bad++; $display("FAIL b2b_first: latency=%0d result=%0d, required 17 %0d", lat1, $signed(res1), $signed(exp1));
    end
    n_cmp++;
    if (lat2 != 17 || res2 !== exp2) begin
      n_bad++; $display("FAIL b2b_second: latency=%0d result=%0d, required 17 %0d", lat2, $signed(res2), $signed(exp2));
    end
  endtask

  task automatic test_reset_mid_run();
    int found, late_done;
    found = 0;
    late_done = 0;
    load_ramp();
    bias = DWIDTH'(32'sd12345);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (sel === 4'd7) begin found = 1; break; end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (found != 1 || {sel, busy, done} !== 6'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: found_sel7=%0d sel=%0d busy=%b done=%b result=%0d, required 1 0 0 0 0",
               found, sel, busy, done, result);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) late_done++;
    end
    n_cmp++;
    if (late_done != 0) begin n_bad++; $display("FAIL mid_reset_no_done: %0d, required 0", late_done); end
    load_ramp();
    check_run("mid_reset_rerun", '0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bias  = '0;
    load_const('0, '0);
    test_reset();
    test_idle();
    test_ramp();
    test_signed();
    test_saturation();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
